usb_desc_relay: RTL and testbench

USB_DESC_RELAY -- requirements
Module: usb_desc_relay

---
 rtl/usb_desc_relay.sv | 343 ++++++++++++++++++++++++++++++++++
 tb/tb_usb_desc_relay.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_desc_relay.sv
// Snoops GET_DESCRIPTOR control transfers off a USB packet stream, buffers the
// returned descriptor and relays it as a framed byte stream (ASCII hex or binary).
module usb_desc_relay #(
    parameter logic [7:0] DESC_TYPE  = 8'h22,
    parameter int         DEPTH_LOG2 = 9,
    parameter int         MAX_PKT    = 64,
    parameter bit         HEX_MODE   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  usb_pid,
    input  logic [7:0]  usb_data,
    input  logic        usb_data_valid,
    input  logic        usb_packet_end,
    input  logic [6:0]  usb_device_addr,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    output logic        busy,
    output logic [15:0] bytes_sent,
    output logic        overflow
);

    localparam int         CAP       = 1 << DEPTH_LOG2;
    localparam int         PW        = DEPTH_LOG2 + 1;
    localparam logic [3:0] PID_SETUP = 4'hD;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [4:0] HDR_LAST  = HEX_MODE ? 5'd17 : 5'd4;
    localparam logic [4:0] FTR_LAST  = HEX_MODE ? 5'd1 : 5'd0;
    localparam logic [15:0] MAX_PKT_W = 16'(MAX_PKT);

    typedef enum logic [2:0] {
        IDLE, WAIT_DATA, CAPTURE, SEND_HDR, SEND_DATA, SEND_FTR
    } state_t;

    typedef enum logic [1:0] {
        PH_FETCH, PH_COMMA, PH_HI, PH_LO
    } phase_t;

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    // ---------------- SETUP packet capture ----------------
    // Counter saturates at 9 so any over-long SETUP never looks like 8 bytes.
    logic [3:0]  setup_cnt_q;
    logic [7:0]  breq_q;
    logic [7:0]  wval_hi_q;
    logic [7:0]  widx_lo_q;
    logic [15:0] wlen_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            setup_cnt_q <= '0;
            breq_q      <= '0;
            wval_hi_q   <= '0;
            widx_lo_q   <= '0;
            wlen_q      <= '0;
        end else if (usb_packet_end) begin
            setup_cnt_q <= '0;
        end else if (usb_data_valid && usb_pid == PID_SETUP) begin
            if (setup_cnt_q != 4'd9) setup_cnt_q <= setup_cnt_q + 4'd1;
            case (setup_cnt_q)
                4'd1:    breq_q       <= usb_data;
                4'd3:    wval_hi_q    <= usb_data;
                4'd4:    widx_lo_q    <= usb_data;
                4'd6:    wlen_q[7:0]  <= usb_data;
                4'd7:    wlen_q[15:8] <= usb_data;
                default: ;
            endcase
        end
    end

    logic setup_valid, trigger, data_pid, data_strobe, data_end;
    assign setup_valid = usb_packet_end && usb_pid == PID_SETUP && setup_cnt_q == 4'd8;
    assign trigger     = setup_valid && breq_q == 8'h06 && wval_hi_q == DESC_TYPE;
    assign data_pid    = usb_pid == PID_DATA0 || usb_pid == PID_DATA1;
    assign data_strobe = usb_data_valid && data_pid;
    assign data_end    = usb_packet_end && data_pid;

    // ---------------- state ----------------
    state_t        state_q, state_d;
    logic [6:0]    addr_q, addr_d;
    logic [7:0]    iface_q, iface_d;
    logic [15:0]   wlen_lat_q, wlen_lat_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [15:0]   rx_total_q, rx_total_d;
    logic [15:0]   pkt_len_q, pkt_len_d;
    logic [4:0]    idx_q, idx_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    phase_t        phase_q, phase_d;
    logic [7:0]    csum_q, csum_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic          tx_cnt_q, tx_cnt_d;
    logic [15:0]   bytes_sent_q, bytes_sent_d;
    logic          overflow_q, overflow_d;

    logic          mem_we;
    logic [7:0]    rd_data_q;
    logic [7:0]    mem [CAP];

    // Registered read: rd_data_q reflects rd_ptr_q from the previous cycle.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= usb_data;
        rd_data_q <= mem[rd_ptr_q[DEPTH_LOG2-1:0]];
    end

    logic [15:0]   len16;
    logic [PW-1:0] rd_next;
    logic [7:0]    hdr_byte;
    logic          out_free;

    assign len16    = 16'(wr_ptr_q);
    assign rd_next  = rd_ptr_q + PW'(1);
    assign out_free = !tx_valid_q || uart_tx_ready;

    always_comb begin
        hdr_byte = 8'h00;
        if (HEX_MODE) begin
            case (idx_q)
                5'd0:    hdr_byte = "[";
                5'd1:    hdr_byte = "D";
                5'd2:    hdr_byte = "E";
                5'd3:    hdr_byte = "S";
                5'd4:    hdr_byte = "C";
                5'd6:    hdr_byte = hexc({1'b0, addr_q[6:4]});
                5'd7:    hdr_byte = hexc(addr_q[3:0]);
                5'd9:    hdr_byte = hexc(iface_q[7:4]);
                5'd10:   hdr_byte = hexc(iface_q[3:0]);
                5'd12:   hdr_byte = hexc(len16[15:12]);
                5'd13:   hdr_byte = hexc(len16[11:8]);
                5'd14:   hdr_byte = hexc(len16[7:4]);
                5'd15:   hdr_byte = hexc(len16[3:0]);
                5'd16:   hdr_byte = "]";
                5'd17:   hdr_byte = "{";
                default: hdr_byte = ":";
            endcase
        end else begin
            case (idx_q)
                5'd0:    hdr_byte = 8'hA5;
                5'd1:    hdr_byte = {1'b0, addr_q};
                5'd2:    hdr_byte = iface_q;
                5'd3:    hdr_byte = len16[15:8];
                default: hdr_byte = len16[7:0];
            endcase
        end
    end

    logic do_arm, do_take, do_send;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        iface_d      = iface_q;
        wlen_lat_d   = wlen_lat_q;
        wr_ptr_d     = wr_ptr_q;
        rx_total_d   = rx_total_q;
        pkt_len_d    = pkt_len_q;
        idx_d        = idx_q;
        rd_ptr_d     = rd_ptr_q;
        phase_d      = phase_q;
        csum_d       = csum_q;
        tx_valid_d   = tx_valid_q && !uart_tx_ready;
        tx_data_d    = tx_data_q;
        tx_cnt_d     = tx_cnt_q && !uart_tx_ready;
        bytes_sent_d = bytes_sent_q;
        overflow_d   = 1'b0;
        mem_we       = 1'b0;
        do_arm       = 1'b0;
        do_take      = 1'b0;
        do_send      = 1'b0;

        if (tx_valid_q && uart_tx_ready && tx_cnt_q) bytes_sent_d = bytes_sent_q + 16'd1;

        case (state_q)
            IDLE: do_arm = trigger;
            WAIT_DATA, CAPTURE: begin
                if (setup_valid) begin
                    state_d = IDLE;
                    do_arm  = trigger;
                end else if (data_end) begin
                    // pkt_len_q is zero in WAIT_DATA, so a zero-length packet ends the transfer
                    if (pkt_len_q < MAX_PKT_W || rx_total_q >= wlen_lat_q) begin
                        do_send = 1'b1;
                    end else begin
                        state_d   = WAIT_DATA;
                        pkt_len_d = '0;
                    end
                end else if (data_strobe) begin
                    state_d = CAPTURE;
                    do_take = 1'b1;
                end
            end
            SEND_HDR: begin
                if (out_free) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = hdr_byte;
                    tx_cnt_d   = 1'b0;
                    if (idx_q != 5'd0) csum_d = csum_q ^ hdr_byte;
                    if (idx_q == HDR_LAST) begin
                        idx_d = '0;
                        if (wr_ptr_q == '0) begin
                            state_d = SEND_FTR;
                        end else begin
                            state_d  = SEND_DATA;
                            rd_ptr_d = '0;
                            phase_d  = PH_FETCH;
                        end
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            SEND_DATA: begin
                case (phase_q)
                    PH_FETCH: begin
                        if (!HEX_MODE)            phase_d = PH_LO;
                        else if (rd_ptr_q != '0)  phase_d = PH_COMMA;
                        else                      phase_d = PH_HI;
                    end
                    PH_COMMA: begin
                        if (out_free) begin
                            tx_valid_d = 1'b1;
                            tx_data_d  = ",";
                            tx_cnt_d   = 1'b0;
                            phase_d    = PH_HI;
                        end
                    end
                    PH_HI: begin
                        if (out_free) begin
                            tx_valid_d = 1'b1;
                            tx_data_d  = hexc(rd_data_q[7:4]);
                            tx_cnt_d   = 1'b0;
                            phase_d    = PH_LO;
                        end
                    end
                    default: begin
                        if (out_free) begin
                            tx_valid_d = 1'b1;
                            tx_data_d  = HEX_MODE ? hexc(rd_data_q[3:0]) : rd_data_q;
                            tx_cnt_d   = 1'b1;
                            csum_d     = csum_q ^ rd_data_q;
                            if (rd_next == wr_ptr_q) begin
                                state_d = SEND_FTR;
                                idx_d   = '0;
                            end else begin
                                rd_ptr_d = rd_next;
                                phase_d  = PH_FETCH;
                            end
                        end
                    end
                endcase
            end
            SEND_FTR: begin
                if (out_free) begin
                    tx_valid_d = 1'b1;
                    tx_cnt_d   = 1'b0;
                    if (HEX_MODE) tx_data_d = (idx_q == 5'd0) ? "}" : 8'h0A;
                    else          tx_data_d = csum_q;
                    if (idx_q == FTR_LAST) state_d = IDLE;
                    else                   idx_d   = idx_q + 5'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_arm) begin
            state_d    = WAIT_DATA;
            addr_d     = usb_device_addr;
            iface_d    = widx_lo_q;
            wlen_lat_d = wlen_q;
            wr_ptr_d   = '0;
            rx_total_d = '0;
            pkt_len_d  = '0;
        end
        if (do_send) begin
            state_d = SEND_HDR;
            idx_d   = '0;
            csum_d  = '0;
        end
        // Bytes beyond wLength are silently dropped; beyond capacity they flag overflow
        if (do_take) begin
            if (rx_total_q != 16'hFFFF) rx_total_d = rx_total_q + 16'd1;
            if (pkt_len_q != 16'hFFFF)  pkt_len_d  = pkt_len_q + 16'd1;
            if (rx_total_q < wlen_lat_q) begin
                if (!wr_ptr_q[PW-1]) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                end else begin
                    overflow_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            iface_q      <= '0;
            wlen_lat_q   <= '0;
            wr_ptr_q     <= '0;
            rx_total_q   <= '0;
            pkt_len_q    <= '0;
            idx_q        <= '0;
            rd_ptr_q     <= '0;
            phase_q      <= PH_FETCH;
            csum_q       <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            tx_cnt_q     <= 1'b0;
            bytes_sent_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            iface_q      <= iface_d;
            wlen_lat_q   <= wlen_lat_d;
            wr_ptr_q     <= wr_ptr_d;
            rx_total_q   <= rx_total_d;
            pkt_len_q    <= pkt_len_d;
            idx_q        <= idx_d;
            rd_ptr_q     <= rd_ptr_d;
            phase_q      <= phase_d;
            csum_q       <= csum_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            tx_cnt_q     <= tx_cnt_d;
            bytes_sent_q <= bytes_sent_d;
            overflow_q   <= overflow_d;
        end
    end

    // busy stays up until the final footer byte leaves the output register
    assign busy          = (state_q != IDLE) || tx_valid_q;
    assign uart_tx_data  = tx_data_q;
    assign uart_tx_valid = tx_valid_q;
    assign bytes_sent    = bytes_sent_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_usb_desc_relay.sv
// Drives one USB stimulus into a hex-framed relay and a small binary-framed relay,
// scoreboarding both output streams against expected frames.
`timescale 1ns/1ps
module tb_usb_desc_relay;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] usb_pid = '0;
    logic [7:0] usb_data = '0;
    logic       usb_data_valid = 1'b0;
    logic       usb_packet_end = 1'b0;
    logic [6:0] usb_device_addr = '0;
    logic       rdy_h = 1'b1, rdy_b = 1'b1;
    logic [7:0] tx_data_h, tx_data_b;
    logic       tx_valid_h, tx_valid_b, busy_h, busy_b, ovf_h, ovf_b;
    logic [15:0] bs_h, bs_b;

    always #5 clk = ~clk;

    usb_desc_relay u_hex (
        .clk(clk), .rst_n(rst_n), .usb_pid(usb_pid), .usb_data(usb_data),
        .usb_data_valid(usb_data_valid), .usb_packet_end(usb_packet_end),
        .usb_device_addr(usb_device_addr), .uart_tx_data(tx_data_h),
        .uart_tx_valid(tx_valid_h), .uart_tx_ready(rdy_h), .busy(busy_h),
        .bytes_sent(bs_h), .overflow(ovf_h)
    );

    usb_desc_relay #(.DEPTH_LOG2(4), .HEX_MODE(1'b0)) u_bin (
        .clk(clk), .rst_n(rst_n), .usb_pid(usb_pid), .usb_data(usb_data),
        .usb_data_valid(usb_data_valid), .usb_packet_end(usb_packet_end),
        .usb_device_addr(usb_device_addr), .uart_tx_data(tx_data_b),
        .uart_tx_valid(tx_valid_b), .uart_tx_ready(rdy_b), .busy(busy_b),
        .bytes_sent(bs_b), .overflow(ovf_b)
    );

    int n_checks = 0;
    int n_pass = 0;
    logic [7:0] q_h[$];
    logic [7:0] q_b[$];
    logic [7:0] pkt [128];
    int ovf_cnt_h = 0, ovf_cnt_b = 0;
    int exp_bs_h = 0, exp_bs_b = 0;
    int ready_mode = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Ready changes just after the rising edge so monitors see the sampled value.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: begin rdy_h = 1'b1; rdy_b = 1'b1; end
            1: begin rdy_h = ($urandom_range(0, 2) != 0); rdy_b = ($urandom_range(0, 2) != 0); end
            default: begin rdy_h = 1'b0; rdy_b = 1'b0; end
        endcase
    end

    logic       ph_v = 1'b0, ph_r = 1'b0, pb_v = 1'b0, pb_r = 1'b0;
    logic [7:0] ph_d = '0, pb_d = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            ph_v = 1'b0;
        end else begin
            if (ph_v && !ph_r) check("hex_hold", {tx_valid_h, tx_data_h}, {1'b1, ph_d});
            if (tx_valid_h && rdy_h) begin
                if (q_h.size() == 0) begin
                    n_checks++;
                    $display("FAIL hex_extra: got %02h expected no byte", tx_data_h);
                end else check("hex_byte", tx_data_h, q_h.pop_front());
            end
            if (ovf_h) ovf_cnt_h++;
            ph_v = tx_valid_h; ph_r = rdy_h; ph_d = tx_data_h;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            pb_v = 1'b0;
        end else begin
            if (pb_v && !pb_r) check("bin_hold", {tx_valid_b, tx_data_b}, {1'b1, pb_d});
            if (tx_valid_b && rdy_b) begin
                if (q_b.size() == 0) begin
                    n_checks++;
                    $display("FAIL bin_extra: got %02h expected no byte", tx_data_b);
                end else check("bin_byte", tx_data_b, q_b.pop_front());
            end
            if (ovf_b) ovf_cnt_b++;
            pb_v = tx_valid_b; pb_r = rdy_b; pb_d = tx_data_b;
        end
    end

    task automatic usb_packet(input logic [3:0] pid, input logic [6:0] addr, input int off, input int n);
        @(negedge clk);
        usb_pid = pid;
        usb_device_addr = addr;
        for (int i = 0; i < n; i++) begin
            usb_data = pkt[off + i];
            usb_data_valid = 1'b1;
            @(negedge clk);
        end
        usb_data_valid = 1'b0;
        usb_packet_end = 1'b1;
        @(negedge clk);
        usb_packet_end = 1'b0;
        usb_pid = 4'h0;
    endtask

    task automatic setup(input logic [6:0] addr, input logic [7:0] iface, input logic [15:0] wlen,
                         input logic [7:0] dtype, input int n);
        pkt[0] = 8'h80; pkt[1] = 8'h06; pkt[2] = 8'h00; pkt[3] = dtype;
        pkt[4] = iface; pkt[5] = 8'h00; pkt[6] = wlen[7:0]; pkt[7] = wlen[15:8];
        pkt[8] = 8'h00;
        usb_packet(4'hD, addr, 0, n);
    endtask

    task automatic push_str_h(input string s);
        for (int k = 0; k < s.len(); k++) q_h.push_back(s[k]);
    endtask

    // Expected frame from the bytes in pkt[0..n-1] as received by the device.
    task automatic expect_frame(input bit hex, input logic [6:0] addr, input logic [7:0] iface,
                                input int n, input int wlen, input int cap);
        int st;
        logic [7:0] cs;
        st = n;
        if (st > wlen) st = wlen;
        if (st > cap) st = cap;
        if (hex) begin
            push_str_h($sformatf("[DESC:%02x:%02x:%04x]{", addr, iface, st[15:0]));
            for (int i = 0; i < st; i++) begin
                if (i != 0) push_str_h(",");
                push_str_h($sformatf("%02x", pkt[i]));
            end
            push_str_h("}\n");
            exp_bs_h += st;
        end else begin
            cs = {1'b0, addr} ^ iface ^ st[15:8] ^ st[7:0];
            q_b.push_back(8'hA5); q_b.push_back({1'b0, addr}); q_b.push_back(iface);
            q_b.push_back(st[15:8]); q_b.push_back(st[7:0]);
            for (int i = 0; i < st; i++) begin
                q_b.push_back(pkt[i]);
                cs = cs ^ pkt[i];
            end
            q_b.push_back(cs);
            exp_bs_b += st;
        end
    endtask

    task automatic wait_done(input string name);
        int k;
        for (k = 0; k < 6000; k++) begin
            @(negedge clk);
            if (!busy_h && !busy_b && q_h.size() == 0 && q_b.size() == 0) break;
        end
        if (k == 6000) begin
            n_checks++;
            $display("FAIL %s_timeout: got %0d/%0d bytes outstanding expected 0", name, q_h.size(), q_b.size());
            q_h.delete();
            q_b.delete();
        end
        repeat (4) @(negedge clk);
        check({name, "_bs_hex"}, bs_h, exp_bs_h[15:0]);
        check({name, "_bs_bin"}, bs_b, exp_bs_b[15:0]);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_valid_h", tx_valid_h, 0);
        check("rst_data_h", tx_data_h, 0);
        check("rst_busy_h", busy_h, 0);
        check("rst_bs_h", bs_h, 0);
        check("rst_valid_b", tx_valid_b, 0);
        check("rst_busy_b", busy_b, 0);
        check("rst_ovf_b", ovf_b, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic 3-byte descriptor.
        setup(7'h00, 8'h00, 16'd3, 8'h22, 8);
        pkt[0] = 8'h05; pkt[1] = 8'h01; pkt[2] = 8'h09;
        push_str_h("[DESC:00:00:0003]{05,01,09}\n");
        exp_bs_h += 3;
        expect_frame(0, 7'h00, 8'h00, 3, 3, 16);
        usb_packet(4'hB, 7'h00, 0, 3);
        wait_done("basic");

        // Binary checksum case, hand-computed: 05^01^00^02^AA^55 = F9.
        setup(7'h05, 8'h01, 16'd2, 8'h22, 8);
        pkt[0] = 8'hAA; pkt[1] = 8'h55;
        push_str_h("[DESC:05:01:0002]{aa,55}\n");
        exp_bs_h += 2;
        q_b.push_back(8'hA5); q_b.push_back(8'h05); q_b.push_back(8'h01); q_b.push_back(8'h00);
        q_b.push_back(8'h02); q_b.push_back(8'hAA); q_b.push_back(8'h55); q_b.push_back(8'hF9);
        exp_bs_b += 2;
        usb_packet(4'h3, 7'h05, 0, 2);
        wait_done("bin_csum");

        // Two-packet transfer: 64 + 36 bytes, wLength 100.
        ovf_cnt_h = 0; ovf_cnt_b = 0;
        setup(7'h12, 8'h02, 16'd100, 8'h22, 8);
        for (int i = 0; i < 100; i++) pkt[i] = 8'(i);
        expect_frame(1, 7'h12, 8'h02, 100, 100, 512);
        expect_frame(0, 7'h12, 8'h02, 100, 100, 16);
        usb_packet(4'h3, 7'h12, 0, 64);
        usb_packet(4'hB, 7'h12, 64, 36);
        wait_done("multi_pkt");
        check("multi_ovf_h", ovf_cnt_h, 0);
        check("multi_ovf_b", ovf_cnt_b, 84);

        // 20 bytes into a 16-byte buffer.
        ovf_cnt_h = 0; ovf_cnt_b = 0;
        setup(7'h21, 8'h00, 16'd20, 8'h22, 8);
        for (int i = 0; i < 20; i++) pkt[i] = 8'hC0 + 8'(i);
        expect_frame(1, 7'h21, 8'h00, 20, 20, 512);
        expect_frame(0, 7'h21, 8'h00, 20, 20, 16);
        usb_packet(4'hB, 7'h21, 0, 20);
        wait_done("ovf");
        check("ovf_cnt_h", ovf_cnt_h, 0);
        check("ovf_cnt_b", ovf_cnt_b, 4);

        // Zero-length DATA packet.
        setup(7'h7F, 8'hAB, 16'd8, 8'h22, 8);
        push_str_h("[DESC:7f:ab:0000]{}\n");
        expect_frame(0, 7'h7F, 8'hAB, 0, 8, 16);
        usb_packet(4'hB, 7'h7F, 0, 0);
        wait_done("zlp");

        // Re-SETUP while waiting for data: only the second request is framed.
        setup(7'h09, 8'h03, 16'd4, 8'h22, 8);
        setup(7'h09, 8'h07, 16'd4, 8'h22, 8);
        pkt[0] = 8'hDE; pkt[1] = 8'hAD; pkt[2] = 8'hBE; pkt[3] = 8'hEF;
        expect_frame(1, 7'h09, 8'h07, 4, 4, 512);
        expect_frame(0, 7'h09, 8'h07, 4, 4, 16);
        usb_packet(4'h3, 7'h09, 0, 4);
        wait_done("restart");

        // Random backpressure.
        ready_mode = 1;
        setup(7'h33, 8'h04, 16'd10, 8'h22, 8);
        for (int i = 0; i < 10; i++) pkt[i] = 8'(i * 23);
        expect_frame(1, 7'h33, 8'h04, 10, 10, 512);
        expect_frame(0, 7'h33, 8'h04, 10, 10, 16);
        usb_packet(4'hB, 7'h33, 0, 10);
        wait_done("stall");
        ready_mode = 0;

        // Non-triggering SETUPs: wrong type, short, long.
        setup(7'h01, 8'h00, 16'd4, 8'h21, 8);
        setup(7'h01, 8'h00, 16'd4, 8'h22, 7);
        setup(7'h01, 8'h00, 16'd4, 8'h22, 9);
        repeat (10) @(negedge clk);
        check("no_trig_busy_h", busy_h, 0);
        check("no_trig_busy_b", busy_b, 0);

        // Reset while a frame is stalled mid-flight.
        ready_mode = 2;
        setup(7'h02, 8'h00, 16'd3, 8'h22, 8);
        pkt[0] = 8'h11; pkt[1] = 8'h22; pkt[2] = 8'h33;
        usb_packet(4'hB, 7'h02, 0, 3);
        begin
            int k;
            for (k = 0; k < 100; k++) begin
                @(negedge clk);
                if (tx_valid_h && tx_valid_b) break;
            end
            if (k == 100) begin
                n_checks++;
                $display("FAIL midrst_start: got no output valid expected valid within 100 cycles");
            end
        end
        rst_n = 1'b0;
        #1;
        check("midrst_valid_h", tx_valid_h, 0);
        check("midrst_busy_h", busy_h, 0);
        check("midrst_valid_b", tx_valid_b, 0);
        check("midrst_bs_b", bs_b, 0);
        exp_bs_h = 0; exp_bs_b = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ready_mode = 0;
        repeat (60) @(negedge clk);
        check("midrst_after_busy_h", busy_h, 0);
        check("midrst_after_bs_h", bs_h, 0);

        check("queue_h_empty", q_h.size(), 0);
        check("queue_b_empty", q_b.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
